pipelined_ripple_adder: RTL and testbench

//   Parametrised, pipelined successor to the team's 16-bit ripple-carry adder.

---
 rtl/pipelined_ripple_adder.sv | 118 +++++++++++
 tb/tb_pipelined_ripple_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_ripple_adder
// Brief    : WIDTH-bit add/subtract split into STAGES registered ripple slices
//            with a valid/ready handshake and global stall.
//            Optional signed-overflow output enabled by PIPE_ADDER_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int C_SW = WIDTH / STAGES;

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    logic [WIDTH-1:0]  w_a_in  [STAGES];
    logic [WIDTH-1:0]  w_b_in  [STAGES];
    logic [WIDTH-1:0]  w_s_in  [STAGES];
    logic [C_SW:0]     w_slice [STAGES];
    logic [WIDTH-1:0]  s_d     [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] c_d;
    logic              w_adv;
    logic              w_unused_ops;

    always_comb begin
        w_adv     = !v_q[STAGES-1] || out_ready;
        // Stage 0 takes the raw operation; b is inverted up front for subtract.
        w_a_in[0] = a;
        w_b_in[0] = sub ? ~b : b;
        w_s_in[0] = '0;
        w_c_in[0] = sub | cin;
        w_v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = a_q[k-1];
            w_b_in[k] = b_q[k-1];
            w_s_in[k] = s_q[k-1];
            w_c_in[k] = c_q[k-1];
            w_v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_a_in[k][k*C_SW +: C_SW]}
                       + {1'b0, w_b_in[k][k*C_SW +: C_SW]}
                       + {{C_SW{1'b0}}, w_c_in[k]};
            s_d[k]                    = w_s_in[k];
            s_d[k][k*C_SW +: C_SW]    = w_slice[k][C_SW-1:0];
            c_d[k]                    = w_slice[k][C_SW];
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1])
                && (s_d[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (w_adv) begin
            v_q <= w_v_in;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= w_a_in[k];
                b_q[k] <= w_b_in[k];
                s_q[k] <= s_d[k];
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    // Operands leaving the final slice have no consumer.
    assign w_unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign in_ready  = w_adv && rst_n;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ripple_adder.sv
`default_nettype none
// Self-checking bench for pipelined_ripple_adder (16/4 main instance, 8/1 extra).
// Optional ovf checks follow PIPE_ADDER_OVF_EN.
module tb_pipelined_ripple_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
    logic         ovf2;
`endif

    logic       in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2;
    logic [7:0] a2, b2, sum2;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    // Reference: plain integer arithmetic, subtract as a - b with borrow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        res_t   r;
        longint t;
        longint sr;
        if (sb) begin
            t  = longint'(x) + (longint'(1) << W) - longint'(y);
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            t  = longint'(x) + longint'(y) + longint'(ci);
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (sr > longint'(2**(W-1) - 1)) || (sr < -longint'(2**(W-1)));
        return r;
    endfunction

    res_t exp_q[$];
    res_t mon_e;
    logic mon_en = 1'b0;
    logic held_v = 1'b0;
    logic [W-1:0] held_s;
    logic held_c;

    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, rst_n && (!out_valid || out_ready));
            if (!rst_n) begin
                exp_q.delete();
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", sum, held_s);
                    check("hold_cout", cout, held_c);
                end
                if (out_valid && out_ready) begin
                    check("result_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("sum", sum, mon_e.s);
                        check("cout", cout, mon_e.c);
`ifdef PIPE_ADDER_OVF_EN
                        check("ovf", ovf, mon_e.o);
`endif
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(a, b, cin, sub));
                held_v = out_valid && !out_ready;
                held_s = sum;
                held_c = cout;
            end
        end
    end

    task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic sb, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string nm);
        int n;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, S);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
`ifdef PIPE_ADDER_OVF_EN
        check({nm, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("note: %s", nm);
`endif
        @(posedge clk); #1;
    endtask

    logic [W-1:0] va [8] = '{16'h1234, 16'hABCD, 16'h8000, 16'hFFFF,
                             16'h0F0F, 16'h7FFF, 16'h0000, 16'hDEAD};
    logic [W-1:0] vb [8] = '{16'h4321, 16'h1111, 16'h8000, 16'hFFFF,
                             16'hF0F0, 16'h8001, 16'h0001, 16'hBEEF};
    logic [7:0]   vc = 8'b1001_1010;
    logic [7:0]   vs = 8'b0110_1100;

    initial begin
        int cnt, first, last, idx, stalls, n;
        logic acc;
        res_t r;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;

        // Pin the reference model against hand-computed values.
        r = model(16'h1234, 16'h4321, 1'b0, 1'b0);
        check("model_add", {r.c, r.s}, 17'h05555);
        r = model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        check("model_add_carry", {r.c, r.s}, 17'h1FFFF);
        r = model(16'h0000, 16'h0001, 1'b0, 1'b1);
        check("model_sub_borrow", {r.c, r.s}, 17'h0FFFF);
        r = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("model_ovf", r.o, 1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        // Carry ripple through every slice, then subtract with and without borrow.
        single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_ripple");
        single(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        single(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
`ifdef PIPE_ADDER_OVF_EN
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
        single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
`endif

        // Streaming: 8 back-to-back ops must yield 8 back-to-back results.
        cnt = 0; first = -1; last = -1;
        for (int t = 0; t < 30; t++) begin
            if (t < 8) begin
                a = va[t]; b = vb[t]; cin = vc[t]; sub = vs[t]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                cnt++;
                if (first < 0) first = t;
                last = t;
            end
        end
        check("stream_count", cnt, 8);
        check("stream_first", first, S - 1);
        check("stream_contiguous", last - first, 7);

        // Backpressure: out_ready low for 3 cycles mid-stream.
        idx = 0; stalls = 0;
        for (int t = 0; t < 60 && (idx < 8 || exp_q.size() != 0); t++) begin
            out_ready = !(t >= 5 && t < 8);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = va[idx] ^ 16'h5A5A; b = vb[idx]; cin = vc[idx]; sub = !vs[idx];
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready) stalls++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_issued", idx, 8);
        check("bp_stall_cycles", stalls, 3);
        check("bp_drained", exp_q.size(), 0);

        // Reset with three operations in flight.
        for (int t = 0; t < 3; t++) begin
            a = va[t + 3]; b = vb[t + 3]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("midrst_no_stale", n, 0);

        // Single-stage 8-bit instance: one-cycle latency.
        a2 = 8'hFF; b2 = 8'h01; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("s1_out_valid", out_valid2, 1);
        check("s1_sum", sum2, 8'h00);
        check("s1_cout", cout2, 1);
`ifdef PIPE_ADDER_OVF_EN
        check("s1_ovf", ovf2, 0);
`endif
        @(posedge clk); #1;
        check("s1_consumed", out_valid2, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
